// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and helpers for the fully-connected layer
//               engine: FSM state encoding, accumulator width derivation,
//               signed saturation and ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

   // Layer evaluation phases
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_BIAS  = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   // Post-accumulation arithmetic is carried at this width so that the
   // biased, pre-shift sum never wraps for any legal DW/IN_CNT/SHIFT.
   localparam int WIDE_W = 64;
   typedef logic signed [WIDE_W-1:0] wide_t;

   // Wide enough for IN_CNT products of two extreme DW-bit values.
   function automatic int acc_width(input int dw, input int in_cnt);
      return 2 * dw + $clog2(in_cnt) + 1;
   endfunction

   // Clamp a signed value to the range of a dw-bit two's complement number.
   function automatic wide_t saturate(input wide_t value, input int dw);
      wide_t max_v;
      wide_t min_v;
      max_v = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      min_v = -(wide_t'(1) <<< (dw - 1));
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

   // Rectified linear unit: negative values become zero.
   function automatic wide_t relu(input wide_t value);
      return (value < wide_t'(0)) ? wide_t'(0) : value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nn_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : nn_mac_lane
// Description : One neuron lane: signed multiply-accumulate over the input
//               stream, then bias add, arithmetic rescale, saturation and
//               optional ReLU into a held output register.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_mac_lane
   import nn_pkg::*;
#(
   parameter int DW    = 8,
   parameter int SHIFT = 0,
   parameter int ACC_W = 20
) (
   input  logic                 clk,
   input  logic                 layerrst_n,
   input  logic                 clr_i,
   input  logic                 mac_en_i,
   input  logic                 bias_en_i,
   input  logic                 relu_i,
   input  logic signed [DW-1:0] data_i,
   input  logic signed [DW-1:0] weight_i,
   input  logic signed [DW-1:0] bias_i,
   output logic signed [DW-1:0] result_o
);

   logic signed [2*DW-1:0]  w_prod;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [DW-1:0]    res_q;
   logic signed [DW-1:0]    res_d;
   wide_t                   w_sum;
   wide_t                   w_scaled;
   wide_t                   w_sat;
   wide_t                   w_act;

   // Next-state for accumulator and result: clear on start, MAC on accepted
   // sample, finalise (bias, shift, clamp, activation) in the BIAS phase.
   always_comb begin
      w_prod   = (2*DW)'(data_i) * (2*DW)'(weight_i);
      // Bias is pre-scaled so it lands on the same fixed-point grid as acc.
      w_sum    = wide_t'(acc_q) + (wide_t'(bias_i) <<< SHIFT);
      w_scaled = w_sum >>> SHIFT;
      w_sat    = saturate(w_scaled, DW);
      w_act    = relu_i ? relu(w_sat) : w_sat;

      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (mac_en_i) begin
         acc_d = acc_q + ACC_W'(w_prod);
      end

      res_d = res_q;
      if (bias_en_i) begin
         res_d = DW'(w_act);
      end
   end

   // Lane state registers
   always_ff @(posedge clk or negedge layerrst_n) begin
      if (!layerrst_n) begin
         acc_q <= '0;
         res_q <= '0;
      end else begin
         acc_q <= acc_d;
         res_q <= res_d;
      end
   end

   assign result_o = res_q;

endmodule
`default_nettype wire

// File: rtl/nn_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : nn_layer_engine
// Description : Fully-connected layer engine. N lanes share one streamed
//               input vector; the controller sequences accumulation, bias
//               finalisation and a valid/ready output handshake, and drives
//               the weight/bias memory read index.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_layer_engine
   import nn_pkg::*;
#(
   parameter int N      = 8,
   parameter int DW     = 8,
   parameter int IN_CNT = 8,
   parameter int SHIFT  = 0,
   parameter int ACC_W  = acc_width(DW, IN_CNT)
) (
   input  logic                       clk,
   input  logic                       layerrst_n,
   input  logic                       start,
   input  logic                       relu_en,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DW-1:0]       in_data,
   output logic [$clog2(IN_CNT)-1:0]  in_idx,
   input  logic [N*DW-1:0]            weight,
   input  logic [N*DW-1:0]            bias,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N*DW-1:0]            out_data,
   output logic                       busy,
   output logic                       done
);

   localparam int                IDX_W    = $clog2(IN_CNT);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IN_CNT - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             relu_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             done_q;

   logic             w_clr;
   logic             w_mac_en;
   logic             w_bias_en;

   // Lane strobes derived from the current phase
   assign w_clr     = (state_q == ST_IDLE)  && start;
   assign w_mac_en  = (state_q == ST_ACCUM) && in_valid;
   assign w_bias_en = (state_q == ST_BIAS);

   // Layer sequencer with registered handshake and status outputs
   always_ff @(posedge clk or negedge layerrst_n) begin
      if (!layerrst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         relu_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_ACCUM;
                  idx_q      <= '0;
                  relu_q     <= relu_en;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  if (idx_q == LAST_IDX) begin
                     idx_q      <= '0;
                     in_ready_q <= 1'b0;
                     state_q    <= ST_BIAS;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_BIAS: begin
               out_valid_q <= 1'b1;
               state_q     <= ST_OUT;
            end
            ST_OUT: begin
               // Start arriving with the handshake is dropped: we are not
               // in IDLE until the following cycle.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Neuron lanes, one per weight/bias/result slice
   for (genvar k = 0; k < N; k++) begin : g_lane
      nn_mac_lane #(
         .DW    (DW),
         .SHIFT (SHIFT),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk        (clk),
         .layerrst_n (layerrst_n),
         .clr_i      (w_clr),
         .mac_en_i   (w_mac_en),
         .bias_en_i  (w_bias_en),
         .relu_i     (relu_q),
         .data_i     (in_data),
         .weight_i   (weight[k*DW +: DW]),
         .bias_i     (bias[k*DW +: DW]),
         .result_o   (out_data[k*DW +: DW])
      );
   end

   assign in_ready  = in_ready_q;
   assign in_idx    = idx_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_layer_engine
// Description : Scoreboard bench for nn_layer_engine. Two instances share
//               stimulus (SHIFT=0 and SHIFT=2); sel picks which one is
//               observed. Expected results are queued at start and popped
//               by an independent monitor on each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_layer_engine;

   localparam int N      = 8;
   localparam int DW     = 8;
   localparam int IN_CNT = 8;
   localparam int IDX_W  = 3;
   localparam int VW     = N * DW;

   logic clk = 1'b0;
   logic layerrst_n = 1'b0;
   logic start = 1'b0;
   logic relu_en = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic sel = 1'b0;
   logic onehot = 1'b0;
   logic [DW-1:0] dval = 8'd1;
   logic [DW-1:0] wval = 8'd1;
   logic [DW-1:0] in_data;
   logic [VW-1:0] weight;
   logic [VW-1:0] bias = '0;

   logic             in_ready_a, in_ready_b, out_valid_a, out_valid_b;
   logic             busy_a, busy_b, done_a, done_b;
   logic [IDX_W-1:0] in_idx_a, in_idx_b;
   logic [VW-1:0]    out_data_a, out_data_b;

   logic             in_ready, out_valid, busy, done;
   logic [IDX_W-1:0] in_idx;
   logic [VW-1:0]    out_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [VW-1:0] exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign in_ready  = sel ? in_ready_b  : in_ready_a;
   assign out_valid = sel ? out_valid_b : out_valid_a;
   assign busy      = sel ? busy_b      : busy_a;
   assign done      = sel ? done_b      : done_a;
   assign in_idx    = sel ? in_idx_b    : in_idx_a;
   assign out_data  = sel ? out_data_b  : out_data_a;

   // External sample/weight memory model addressed by in_idx
   always_comb begin
      in_data = onehot ? (DW'(in_idx) + 8'd1) : dval;
      weight  = '0;
      for (int k = 0; k < N; k++) begin
         weight[k*DW +: DW] = onehot ? ((int'(in_idx) == k) ? 8'd1 : 8'd0) : wval;
      end
   end

   nn_layer_engine #(.N(N), .DW(DW), .IN_CNT(IN_CNT), .SHIFT(0)) u_dut_a (
      .clk(clk), .layerrst_n(layerrst_n), .start(start), .relu_en(relu_en),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .in_idx(in_idx_a), .weight(weight), .bias(bias),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .busy(busy_a), .done(done_a)
   );

   nn_layer_engine #(.N(N), .DW(DW), .IN_CNT(IN_CNT), .SHIFT(2)) u_dut_b (
      .clk(clk), .layerrst_n(layerrst_n), .start(start), .relu_en(relu_en),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .in_idx(in_idx_b), .weight(weight), .bias(bias),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output handshake is matched against the scoreboard
   always @(negedge clk) begin
      logic [VW-1:0] e;
      if (layerrst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("result", out_data, e);
         end
      end
   end

   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic run_layer(input string tag, input logic r, input logic [31:0] stall_mask,
                            input int ready_delay, input int exp_lat, input logic hold_start,
                            input logic [VW-1:0] exp);
      int t_start, fc, acc, guard, d0;
      logic hs;
      logic [VW-1:0] cap;
      exp_q.push_back(exp);
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      relu_en = r;
      t_start = cyc;
      @(negedge clk);
      chk({tag, " busy_c0"}, VW'(busy), VW'(0));
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      relu_en = ~r;
      acc = 0;
      fc = 0;
      while (acc < IN_CNT && fc < 32) begin
         in_valid = !stall_mask[fc];
         @(negedge clk);
         if (fc == 0) begin
            chk({tag, " busy_c1"}, VW'(busy), VW'(1));
            chk({tag, " in_ready_c1"}, VW'(in_ready), VW'(1));
         end
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) acc++;
         fc++;
      end
      in_valid = 1'b0;
      chk({tag, " samples"}, VW'(acc), VW'(IN_CNT));
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!out_valid && guard < 40);
      chk({tag, " out_valid"}, VW'(out_valid), VW'(1));
      if (exp_lat > 0) chk({tag, " latency"}, VW'(cyc - t_start), VW'(exp_lat));
      cap = out_data;
      for (int i = 0; i < ready_delay; i++) begin
         @(negedge clk);
         chk({tag, " hold_valid"}, VW'(out_valid), VW'(1));
         chk({tag, " hold_data"}, out_data, cap);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk({tag, " done_pulse"}, VW'(done), VW'(1));
      chk({tag, " valid_drop"}, VW'(out_valid), VW'(0));
      chk({tag, " busy_drop"}, VW'(busy), VW'(0));
      @(negedge clk);
      chk({tag, " done_single"}, VW'(done), VW'(0));
      chk({tag, " idle_after"}, VW'(busy), VW'(0));
      chk({tag, " done_count"}, VW'(done_cnt - d0), VW'(1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " in_ready"}, VW'(in_ready), VW'(0));
      chk({tag, " in_idx"}, VW'(in_idx), VW'(0));
      chk({tag, " out_valid"}, VW'(out_valid), VW'(0));
      chk({tag, " out_data"}, out_data, VW'(0));
      chk({tag, " busy"}, VW'(busy), VW'(0));
      chk({tag, " done"}, VW'(done), VW'(0));
   endtask

   task automatic reset_mid();
      int guard;
      @(posedge clk); #1;
      start = 1'b1;
      relu_en = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      guard = 0;
      while (in_idx != 3'd4 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("abort at_idx4", VW'(in_idx), VW'(4));
      #2;
      layerrst_n = 1'b0;
      #1;
      chk_reset_vals("abort async");
      in_valid = 1'b0;
      @(negedge clk);
      chk_reset_vals("abort held");
      @(posedge clk); #1;
      layerrst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort no_output", VW'(out_valid), VW'(0));
      chk("abort idle", VW'(busy), VW'(0));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      layerrst_n = 1'b1;

      dval = 8'd1; wval = 8'd1; bias = '0;
      run_layer("basic", 1'b0, 32'h0, 0, 10, 1'b0, {N{8'd8}});

      dval = 8'd127; wval = 8'd127;
      run_layer("sat_pos", 1'b0, 32'h0, 0, 10, 1'b0, {N{8'h7f}});
      wval = 8'h80;
      run_layer("sat_neg", 1'b0, 32'h0, 0, 10, 1'b0, {N{8'h80}});

      dval = 8'd1; wval = 8'hff; bias = {N{8'd2}};
      run_layer("linear", 1'b0, 32'h0, 0, 10, 1'b0, {N{8'hfa}});
      run_layer("relu", 1'b1, 32'h0, 0, 10, 1'b0, {N{8'h00}});

      onehot = 1'b1;
      bias = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      run_layer("lanes", 1'b1, 32'h0, 0, 10, 1'b0,
                {8'd15, 8'd13, 8'd11, 8'd9, 8'd7, 8'd5, 8'd3, 8'd1});
      onehot = 1'b0;

      dval = 8'd1; wval = 8'd1; bias = '0;
      run_layer("in_stall", 1'b0, 32'h124, 0, 13, 1'b0, {N{8'd8}});
      run_layer("out_stall", 1'b0, 32'h0, 5, 10, 1'b0, {N{8'd8}});

      reset_mid();
      run_layer("after_reset", 1'b0, 32'h0, 0, 10, 1'b0, {N{8'd8}});

      run_layer("hold_start", 1'b0, 32'h0, 0, 10, 1'b1, {N{8'd8}});

      sel = 1'b1;
      dval = 8'd2; wval = 8'd3; bias = {N{8'd1}};
      run_layer("shift_pos", 1'b0, 32'h0, 0, 10, 1'b0, {N{8'd13}});
      dval = 8'hfe; bias = {N{8'hff}};
      run_layer("shift_neg", 1'b0, 32'h0, 0, 10, 1'b0, {N{8'hf3}});

      chk("scoreboard_empty", VW'(exp_q.size()), VW'(0));
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
